// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the sequential divider
//
// Contents:
//   state_t     : controller states IDLE, CALC, DONE
//   DATA_W_DEF  : default operand width
//   RES_W_DEF   : default result width (2 * DATA_W_DEF)
//   CNT_W       : iteration counter width
//   ALL_ONES    : divide-by-zero result pattern, sliced to RES_W by users
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RES_W_DEF  = 2 * DATA_W_DEF;
    localparam int CNT_W      = 5;

    localparam logic [63:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring divide iteration
//
// Ports:
//   rem_in  [DATA_W-1:0] : partial remainder entering this iteration
//   bit_in               : next dividend bit (MSB first)
//   divisor [DATA_W-1:0] : divisor magnitude
//   rem_out [DATA_W-1:0] : partial remainder after this iteration
//   q_bit                : quotient bit produced by this iteration
module div_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The shifted remainder needs one extra bit; it is always below
    // 2*divisor, so a successful subtraction fits back in DATA_W bits.
    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {1'b0, divisor};

    // No borrow out of the top bit means shifted >= divisor.
    assign q_bit   = ~trial[DATA_W];
    assign rem_out = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
//
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands,
// quotient truncates toward zero, remainder follows the dividend sign).
//
// Ports:
//   clk                  : clock, rising edge
//   rst_n                : asynchronous active-low reset
//   start                : request a division, sampled only in IDLE
//   inputA  [DATA_W-1:0] : dividend, captured on the accepting edge
//   inputB  [DATA_W-1:0] : divisor, captured on the accepting edge
//   busy                 : high while iterating
//   done                 : one-cycle pulse, results valid
//   resDiv  [RES_W-1:0]  : quotient, extended to RES_W
//   resMod  [RES_W-1:0]  : remainder, extended to RES_W
//   divZero              : last accepted divisor was zero
module seq_divider
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] inputA,
    input  logic [DATA_W-1:0] inputB,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  resDiv,
    output logic [RES_W-1:0]  resMod,
    output logic              divZero
);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dq_q;     // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] dvs_q;

    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic              last_iter;
    logic              b_zero;

    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] q_fin;
    logic [RES_W-1:0]  div_ext;
    logic [RES_W-1:0]  mod_ext;

    assign b_zero    = (inputB == '0);
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    assign q_fin     = {dq_q[DATA_W-2:0], step_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;

    // Magnitudes are taken as unsigned DATA_W values, so the most negative
    // operand maps to 2^(DATA_W-1) without overflow.
    assign mag_a   = inputA[DATA_W-1] ? (-inputA) : inputA;
    assign mag_b   = inputB[DATA_W-1] ? (-inputB) : inputB;
    assign div_ext = neg_q_q ? (-RES_W'(q_fin))   : RES_W'(q_fin);
    assign mod_ext = neg_r_q ? (-RES_W'(step_rem)) : RES_W'(step_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_q_q <= inputA[DATA_W-1] ^ inputB[DATA_W-1];
            neg_r_q <= inputA[DATA_W-1];
        end
    end
`else
    assign mag_a   = inputA;
    assign mag_b   = inputB;
    assign div_ext = RES_W'(q_fin);
    assign mod_ext = RES_W'(step_rem);
`endif

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dq_q[DATA_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            resDiv  <= '0;
            resMod  <= '0;
            divZero <= 1'b0;
        end else begin
            // Registered from the next state so both flags are glitch-free.
            busy <= (state_d == CALC);
            done <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        dq_q  <= mag_a;
                        dvs_q <= mag_b;
                        if (b_zero) begin
                            resDiv  <= ALL_ONES[RES_W-1:0];
                            resMod  <= ALL_ONES[RES_W-1:0];
                            divZero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    rem_q <= step_rem;
                    dq_q  <= q_fin;
                    if (last_iter) begin
                        cnt_q   <= '0;
                        resDiv  <= div_ext;
                        resMod  <= mod_ext;
                        divZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized scoreboard bench for seq_divider
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] inputA;
    logic [15:0] inputB;
    logic        busy;
    logic        done;
    logic [31:0] resDiv;
    logic [31:0] resMod;
    logic        divZero;

    seq_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .inputA  (inputA),
        .inputB  (inputB),
        .busy    (busy),
        .done    (done),
        .resDiv  (resDiv),
        .resMod  (resMod),
        .divZero (divZero)
    );

    typedef struct {
        logic [31:0] div;
        logic [31:0] md;
        logic        dz;
        int          done_cyc;
        int          busy_n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operands as the spec defines them.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int now);
        exp_t e;
        if (b == 16'd0) begin
            e.div = 32'hFFFF_FFFF;
            e.md  = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.done_cyc = now + 1;
            e.busy_n   = 0;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            int sa, sbv;
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            e.div = 32'(sa / sbv);
            e.md  = 32'(sa % sbv);
`else
            e.div = {16'd0, a / b};
            e.md  = {16'd0, a % b};
`endif
            e.dz  = 1'b0;
            e.done_cyc = now + 17;
            e.busy_n   = 16;
        end
        return e;
    endfunction

    // Called at a falling edge where start=1 and the DUT will accept on the next edge.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        sb.push_back(model(a, b, cyc));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resDiv",   64'(resDiv),   64'(e.div));
                    check("resMod",   64'(resMod),   64'(e.md));
                    check("divZero",  64'(divZero),  64'(e.dz));
                    check("done_cyc", 64'(cyc),      64'(e.done_cyc));
                    check("busy_len", 64'(busy_cnt), 64'(e.busy_n));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        inputA = a;
        inputB = b;
        start  = 1'b1;
        push_exp(a, b);
        @(negedge clk);
        start  = 1'b0;
        inputA = 16'($urandom);
        inputB = 16'($urandom);
        wait_empty();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_done"},    64'(done),    64'd0);
        check({tag, "_resDiv"},  64'(resDiv),  64'd0);
        check({tag, "_resMod"},  64'(resMod),  64'd0);
        check({tag, "_divZero"}, 64'(divZero), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] a, b;
        rst_n  = 1'b0;
        start  = 1'b1;
        inputA = 16'd9;
        inputB = 16'd3;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Release reset and request on the same falling edge: first rising
        // edge after deassertion must accept.
        rst_n  = 1'b1;
        inputA = 16'd6;
        inputB = 16'd1;
        push_exp(16'd6, 16'd1);
        @(negedge clk);
        start = 1'b0;
        wait_empty();

        run_op(16'd100, 16'd7);
        run_op(16'd5, 16'd0);
        run_op(16'd0, 16'd5);
        run_op(16'hFFFF, 16'd1);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'd1, 16'hFFFF);
        run_op(16'd0, 16'd0);
        run_op(16'h8000, 16'd3);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(16'hFFF9, 16'd2);
        run_op(16'h8000, 16'hFFFF);
        run_op(16'd7, 16'hFFFE);
`endif

        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'd0;
                1, 2, 3: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            run_op(a, b);
        end

        // start held high; operands churn during CALC. The second request is
        // taken on the edge after DONE->IDLE, two edges after done appears.
        k = cyc;
        inputA = 16'd50;
        inputB = 16'd3;
        start  = 1'b1;
        push_exp(16'd50, 16'd3);
        while (cyc < k + 18) begin
            @(negedge clk);
            inputA = 16'($urandom);
            inputB = 16'($urandom_range(1, 65535));
        end
        push_exp(inputA, inputB);
        @(negedge clk);
        start  = 1'b0;
        wait_empty();

        // Reset in the eighth CALC cycle aborts; no done may follow.
        k = cyc;
        inputA = 16'd1234;
        inputB = 16'd11;
        start  = 1'b1;
        push_exp(16'd1234, 16'd11);
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        sb.delete();
        repeat (2) @(negedge clk);
        check_zero_outputs("held_reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op(16'd1000, 16'd9);
        run_op(16'd4321, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
